// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, Val2 shifter, ALU, NZCV flags,
// branch target and the EXE/MEM pipeline register.
module exe_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic        b_in,
    input  logic        s_in,
    input  logic        cin,
    input  logic [3:0]  exe_cmd_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] val_Rn_in,
    input  logic [31:0] val_Rm_in,
    input  logic        imm_in,
    input  logic [11:0] shift_operand_in,
    input  logic [23:0] signed_imm_24_in,
    input  logic [3:0]  dest_in,
    input  logic [1:0]  sel_src1,
    input  logic [1:0]  sel_src2,
    input  logic [31:0] mem_fwd,
    input  logic [31:0] wb_fwd,
    output logic        branch_taken,
    output logic [31:0] branch_addr,
    output logic [3:0]  status,
    output logic        wb_en,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic [31:0] alu_res,
    output logic [31:0] val_Rm,
    output logic [3:0]  dest
);

    logic [31:0] op_a;
    logic [31:0] rm_fwd;
    logic [31:0] val2;
    logic [31:0] imm8;
    logic [5:0]  imm_rot;
    logic [4:0]  sh_amt;
    logic [31:0] imm_val;
    logic [31:0] rm_ror;
    logic [32:0] add_r;
    logic [32:0] adc_r;
    logic [32:0] sub_r;
    logic [32:0] sbc_r;
    logic [31:0] alu_out;
    logic        c_nxt;
    logic        v_nxt;

    assign branch_taken = b_in;
    assign branch_addr  = pc_in + {{6{signed_imm_24_in[23]}},
                                   signed_imm_24_in, 2'b00};

    always_comb begin
        unique case (sel_src1)
            2'b01:   op_a = mem_fwd;
            2'b10:   op_a = wb_fwd;
            default: op_a = val_Rn_in;
        endcase
        unique case (sel_src2)
            2'b01:   rm_fwd = mem_fwd;
            2'b10:   rm_fwd = wb_fwd;
            default: rm_fwd = val_Rm_in;
        endcase
    end

    // Shifts by >= 32 yield 0, so a zero rotate leaves the value intact
    assign imm8    = {24'b0, shift_operand_in[7:0]};
    assign imm_rot = {1'b0, shift_operand_in[11:8], 1'b0};
    assign imm_val = (imm8 >> imm_rot) | (imm8 << (6'd32 - imm_rot));
    assign sh_amt  = shift_operand_in[11:7];
    assign rm_ror  = (rm_fwd >> sh_amt)
                   | (rm_fwd << (6'd32 - {1'b0, sh_amt}));

    always_comb begin
        val2 = rm_fwd;
        if (mem_r_en_in | mem_w_en_in) begin
            val2 = {20'b0, shift_operand_in};
        end else if (imm_in) begin
            val2 = imm_val;
        end else begin
            unique case (shift_operand_in[6:5])
                2'b00: val2 = rm_fwd << sh_amt;
                2'b01: val2 = rm_fwd >> sh_amt;
                2'b10: val2 = $signed(rm_fwd) >>> sh_amt;
                2'b11: val2 = rm_ror;
            endcase
        end
    end

    assign add_r = {1'b0, op_a} + {1'b0, val2};
    assign adc_r = {1'b0, op_a} + {1'b0, val2} + {32'b0, cin};
    assign sub_r = {1'b0, op_a} + {1'b0, ~val2} + 33'd1;
    assign sbc_r = {1'b0, op_a} + {1'b0, ~val2} + {32'b0, cin};

    always_comb begin
        alu_out = 32'b0;
        c_nxt   = status[1];
        v_nxt   = status[0];
        case (exe_cmd_in)
            4'b0001: alu_out = val2;
            4'b1001: alu_out = ~val2;
            4'b0010: begin
                {c_nxt, alu_out} = add_r;
                v_nxt = (op_a[31] == val2[31]) & (add_r[31] != op_a[31]);
            end
            4'b0011: begin
                {c_nxt, alu_out} = adc_r;
                v_nxt = (op_a[31] == val2[31]) & (adc_r[31] != op_a[31]);
            end
            4'b0100: begin
                {c_nxt, alu_out} = sub_r;
                v_nxt = (op_a[31] != val2[31]) & (sub_r[31] != op_a[31]);
            end
            4'b0101: begin
                {c_nxt, alu_out} = sbc_r;
                v_nxt = (op_a[31] != val2[31]) & (sbc_r[31] != op_a[31]);
            end
            4'b0110: alu_out = op_a & val2;
            4'b0111: alu_out = op_a | val2;
            4'b1000: alu_out = op_a ^ val2;
            default: alu_out = 32'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status   <= 4'b0;
            wb_en    <= 1'b0;
            mem_r_en <= 1'b0;
            mem_w_en <= 1'b0;
            alu_res  <= 32'b0;
            val_Rm   <= 32'b0;
            dest     <= 4'b0;
        end else if (!freeze) begin
            wb_en    <= wb_en_in;
            mem_r_en <= mem_r_en_in;
            mem_w_en <= mem_w_en_in;
            alu_res  <= alu_out;
            val_Rm   <= rm_fwd;
            dest     <= dest_in;
            if (s_in) begin
                status <= {alu_out[31], alu_out == 32'b0, c_nxt, v_nxt};
            end
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Randomized bench for exe_stage against an arithmetic reference model,
// plus directed literal cases.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic        b_in;
    logic        s_in;
    logic        cin;
    logic [3:0]  exe_cmd_in;
    logic [31:0] pc_in;
    logic [31:0] val_Rn_in;
    logic [31:0] val_Rm_in;
    logic        imm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;
    logic [3:0]  dest_in;
    logic [1:0]  sel_src1;
    logic [1:0]  sel_src2;
    logic [31:0] mem_fwd;
    logic [31:0] wb_fwd;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [3:0]  status;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_res;
    logic [31:0] val_Rm;
    logic [3:0]  dest;

    int n_checks = 0;
    int n_err = 0;
    bit check_en = 0;

    logic [3:0]  e_status;
    logic        e_wb, e_mr, e_mw;
    logic [31:0] e_alu, e_rm;
    logic [3:0]  e_dest;

    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -64'sd2147483648;

    exe_stage dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
        .mem_w_en_in(mem_w_en_in), .b_in(b_in), .s_in(s_in),
        .cin(cin), .exe_cmd_in(exe_cmd_in), .pc_in(pc_in),
        .val_Rn_in(val_Rn_in), .val_Rm_in(val_Rm_in),
        .imm_in(imm_in), .shift_operand_in(shift_operand_in),
        .signed_imm_24_in(signed_imm_24_in), .dest_in(dest_in),
        .sel_src1(sel_src1), .sel_src2(sel_src2),
        .mem_fwd(mem_fwd), .wb_fwd(wb_fwd),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .status(status), .wb_en(wb_en), .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en), .alu_res(alu_res), .val_Rm(val_Rm),
        .dest(dest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ror1(input logic [31:0] v, input int n);
        logic [31:0] r = v;
        for (int i = 0; i < n; i++) r = (r >> 1) | ((r & 32'd1) << 31);
        return r;
    endfunction

    function automatic logic [31:0] asr(input logic [31:0] v, input int n);
        logic [31:0] r = v;
        for (int i = 0; i < n; i++) r = (r >> 1) | (r & 32'h80000000);
        return r;
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] s,
                                         input logic [31:0] reg_v);
        if (s == 2'd1) return mem_fwd;
        if (s == 2'd2) return wb_fwd;
        return reg_v;
    endfunction

    function automatic logic [31:0] m_val2(input logic [31:0] rm);
        int so = int'(shift_operand_in);
        int amt = so / 128;
        int typ = (so / 32) % 4;
        if (mem_r_en_in || mem_w_en_in) return 32'(so);
        if (imm_in) return ror1(32'(so % 256), 2 * (so / 256));
        case (typ)
            0: return rm << amt;
            1: return rm >> amt;
            2: return asr(rm, amt);
            default: return ror1(rm, amt);
        endcase
    endfunction

    task automatic m_alu(input logic [3:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input logic ci,
                         output logic [31:0] r, output bit arith,
                         output logic c, output logic v);
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint t, st, k;
        arith = 0; c = 0; v = 0; r = 0;
        case (cmd)
            4'd1: r = b;
            4'd9: r = ~b;
            4'd6: r = a & b;
            4'd7: r = a | b;
            4'd8: r = a ^ b;
            4'd2, 4'd3: begin
                k = (cmd == 4'd3 && ci) ? 1 : 0;
                t = ua + ub + k;
                st = sa + sb + k;
                r = t[31:0];
                c = t > 64'sd4294967295;
                v = st > MAXI || st < MINI;
                arith = 1;
            end
            4'd4, 4'd5: begin
                k = (cmd == 4'd5 && !ci) ? 1 : 0;
                t = ua - ub - k;
                st = sa - sb - k;
                r = t[31:0];
                c = t >= 0;
                v = st > MAXI || st < MINI;
                arith = 1;
            end
            default: r = 0;
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        logic [31:0] a, rmv, b, r;
        logic c, v;
        bit ar;
        if (rst) begin
            e_status = 0; e_wb = 0; e_mr = 0; e_mw = 0;
            e_alu = 0; e_rm = 0; e_dest = 0;
        end else if (!freeze) begin
            a = pick(sel_src1, val_Rn_in);
            rmv = pick(sel_src2, val_Rm_in);
            b = m_val2(rmv);
            m_alu(exe_cmd_in, a, b, cin, r, ar, c, v);
            if (s_in)
                e_status = {r[31], r == 0, ar ? c : e_status[1],
                            ar ? v : e_status[0]};
            e_alu = r; e_rm = rmv; e_dest = dest_in;
            e_wb = wb_en_in; e_mr = mem_r_en_in; e_mw = mem_w_en_in;
        end
    end

    always @(negedge clk) begin
        int off;
        if (check_en) begin
            off = int'($signed(signed_imm_24_in)) * 4;
            chk("status", 32'(status), 32'(e_status));
            chk("alu_res", alu_res, e_alu);
            chk("val_Rm", val_Rm, e_rm);
            chk("dest", 32'(dest), 32'(e_dest));
            chk("wb_en", 32'(wb_en), 32'(e_wb));
            chk("mem_r_en", 32'(mem_r_en), 32'(e_mr));
            chk("mem_w_en", 32'(mem_w_en), 32'(e_mw));
            chk("branch_taken", 32'(branch_taken), 32'(b_in));
            chk("branch_addr", branch_addr, pc_in + 32'(off));
        end
    end

    task automatic idle();
        freeze = 0; wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
        b_in = 0; s_in = 0; cin = 0; exe_cmd_in = 0; pc_in = 0;
        val_Rn_in = 0; val_Rm_in = 0; imm_in = 0;
        shift_operand_in = 0; signed_imm_24_in = 0; dest_in = 0;
        sel_src1 = 0; sel_src2 = 0; mem_fwd = 0; wb_fwd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_alu"}, alu_res, 32'h0);
        chk({tag, "_status"}, 32'(status), 32'h0);
        chk({tag, "_val_Rm"}, val_Rm, 32'h0);
        chk({tag, "_ctl"}, {25'b0, wb_en, mem_r_en, mem_w_en, dest}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_zero("reset");
        check_en = 1;

        exe_cmd_in = 4'd2; val_Rn_in = 32'h7FFFFFFF; imm_in = 1;
        shift_operand_in = 12'h001; s_in = 1; wb_en_in = 1; dest_in = 4'd3;
        tick();
        chk("add_ovf_res", alu_res, 32'h80000000);
        chk("add_ovf_nzcv", 32'(status), 32'b1001);

        idle();
        exe_cmd_in = 4'd4; val_Rn_in = 5; val_Rm_in = 5; s_in = 1;
        tick();
        chk("sub_eq_res", alu_res, 32'h0);
        chk("sub_eq_nzcv", 32'(status), 32'b0110);

        exe_cmd_in = 4'd2; val_Rn_in = 32'h7FFFFFFF; imm_in = 1;
        shift_operand_in = 12'h001; s_in = 0;
        tick();
        chk("nos_res", alu_res, 32'h80000000);
        chk("nos_nzcv", 32'(status), 32'b0110);

        idle();
        exe_cmd_in = 4'd1; imm_in = 1; shift_operand_in = 12'h4FF;
        tick();
        chk("imm_rot", alu_res, 32'hFF000000);

        idle();
        exe_cmd_in = 4'd1; val_Rm_in = 32'h80000000;
        shift_operand_in = 12'h240;
        tick();
        chk("asr4", alu_res, 32'hF8000000);

        idle();
        exe_cmd_in = 4'd2; mem_w_en_in = 1; sel_src1 = 2'b01;
        mem_fwd = 32'h10; shift_operand_in = 12'h004; sel_src2 = 2'b10;
        wb_fwd = 32'hABCD1234; val_Rm_in = 32'h55555555;
        tick();
        chk("str_addr", alu_res, 32'h14);
        chk("str_data", val_Rm, 32'hABCD1234);
        chk("str_wen", 32'(mem_w_en), 32'h1);

        idle();
        freeze = 1; exe_cmd_in = 4'd2; val_Rn_in = 1; imm_in = 1;
        shift_operand_in = 12'h001; s_in = 1; wb_en_in = 1;
        tick();
        chk("frz_alu", alu_res, 32'h14);
        chk("frz_nzcv", 32'(status), 32'b0110);
        chk("frz_data", val_Rm, 32'hABCD1234);

        idle();
        b_in = 1; pc_in = 32'h100; signed_imm_24_in = 24'hFFFFFE;
        #1;
        chk("br_addr", branch_addr, 32'h000000F8);
        chk("br_taken", 32'(branch_taken), 32'h1);
        tick();

        idle();
        exe_cmd_in = 4'd2; val_Rn_in = 32'h1234; val_Rm_in = 32'h99;
        s_in = 1; wb_en_in = 1; dest_in = 4'd7;
        tick();
        #2 rst = 1'b1;
        #1 chk_zero("midrst");
        tick();
        rst = 1'b0;
        idle();
        chk_zero("postrst");

        for (int i = 0; i < 600; i++) begin
            freeze = ($urandom_range(0, 4) == 0);
            wb_en_in = 1'($urandom);
            mem_r_en_in = ($urandom_range(0, 7) == 0);
            mem_w_en_in = ($urandom_range(0, 7) == 0);
            b_in = 1'($urandom);
            s_in = 1'($urandom);
            cin = 1'($urandom);
            exe_cmd_in = 4'($urandom);
            pc_in = $urandom;
            val_Rn_in = ($urandom_range(0, 5) == 0) ? 32'h7FFFFFFF : $urandom;
            val_Rm_in = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            imm_in = 1'($urandom);
            shift_operand_in = 12'($urandom);
            signed_imm_24_in = 24'($urandom);
            dest_in = 4'($urandom);
            sel_src1 = 2'($urandom);
            sel_src2 = 2'($urandom);
            mem_fwd = $urandom;
            wb_fwd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 9) == 0) idle();
            tick();
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
